// File: rtl/addsub_div_sequencer.sv
// addsub_div_sequencer: multi-cycle unsigned restoring divider controller.
// It drives a shared, external WIDTH+1-bit adder/subtractor in subtract mode
// once per iteration and presents a start/busy/done handshake.
//
// Optional feature: define ADDSUB_DIV_ABORT_EN to add an "abort" input that
// cancels a division in flight without a done pulse.
//
// Handshake: a request is taken only when start=1 at a clock edge while the
// FSM is IDLE. busy is high while a division is in progress (ITER, DONE).
// done is a one-cycle pulse marking quotient/remainder/div_by_zero valid.
// Results hold until the next accepted start. start outside IDLE is dropped.
module addsub_div_sequencer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef ADDSUB_DIV_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [WIDTH:0]   as_a,
    output logic [WIDTH:0]   as_b,
    output logic             as_s,
    input  logic [WIDTH:0]   as_answer
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             abort_req;

`ifdef ADDSUB_DIV_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Shared adder operands: trial subtraction in ITER, quiescent otherwise.
    always_comb begin
        as_a = '0;
        as_b = '0;
        as_s = 1'b0;
        if (state == ITER) begin
            as_a = {r_q, q_q[WIDTH-1]};
            as_b = {1'b0, d_q};
            as_s = 1'b1;
        end
    end

    // Restoring step: keep the difference when non-negative, else restore.
    always_comb begin
        if (as_answer[WIDTH]) begin
            r_next = as_a[WIDTH-1:0];
        end else begin
            r_next = as_answer[WIDTH-1:0];
        end
        q_next = {q_q[WIDTH-2:0], ~as_answer[WIDTH]};
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            count       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor != '0) begin
                            d_q         <= divisor;
                            q_q         <= dividend;
                            r_q         <= '0;
                            count       <= CW'(WIDTH - 1);
                            div_by_zero <= 1'b0;
                            state       <= ITER;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                ITER: begin
                    if (abort_req) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        r_q   <= r_next;
                        q_q   <= q_next;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            quotient  <= q_next;
                            remainder <= r_next;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_div_sequencer.sv
// Directed + randomized bench for addsub_div_sequencer. The shared adder is
// modelled here; expected results come from integer / and % and are queued
// when a request is driven, then popped when done is seen.
module tb_addsub_div_sequencer;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
`ifdef ADDSUB_DIV_ABORT_EN
    logic           abort;
`endif
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic [W:0]     as_a;
    logic [W:0]     as_b;
    logic           as_s;
    logic [W:0]     as_answer;

    logic [2*W:0]   exp_q[$];
    int             pass_cnt = 0;
    int             check_cnt = 0;
    int unsigned    cyc = 0;
    int unsigned    acc = 0;

    addsub_div_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef ADDSUB_DIV_ABORT_EN
        .abort       (abort),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .as_a        (as_a),
        .as_b        (as_b),
        .as_s        (as_s),
        .as_answer   (as_answer)
    );

    // clock and the shared adder/subtractor model
    always #5 clk = ~clk;
    assign as_answer = as_s ? (as_a - as_b) : (as_a + as_b);
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Enter and leave at a negedge; request is accepted at the next posedge.
    task automatic do_start(input logic [W-1:0] dd, input logic [W-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        if (dv == '0) exp_q.push_back({{W{1'b1}}, dd, 1'b1});
        else          exp_q.push_back({W'(dd / dv), W'(dd % dv), 1'b0});
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
    endtask

    task automatic wait_done(input int exp_lat);
        logic [2*W:0] e;
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check("done_timeout", 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 0);
        end else begin
            e = exp_q.pop_front();
            check("latency", cyc - acc, exp_lat);
            check("quotient", 32'(quotient), 32'(e[2*W:W+1]));
            check("remainder", 32'(remainder), 32'(e[W:1]));
            check("div_by_zero", 32'(div_by_zero), 32'(e[0]));
            check("busy_in_done", 32'(busy), 1);
            @(negedge clk);
            check("done_width", 32'(done), 0);
            check("busy_idle", 32'(busy), 0);
        end
    endtask

    task automatic expect_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("no_done", 32'(done), 0);
        end
    endtask

    initial begin
        logic [W-1:0] rdd;
        logic [W-1:0] rdv;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef ADDSUB_DIV_ABORT_EN
        abort    = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        check("rst_as_a", 32'(as_a), 0);
        check("rst_as_s", 32'(as_s), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: 43/5, with first-iteration adder operands
        do_start(6'd43, 6'd5);
        check("iter1_as_a", 32'(as_a), 1);
        check("iter1_as_b", 32'(as_b), 5);
        check("iter1_as_s", 32'(as_s), 1);
        check("iter1_busy", 32'(busy), 1);
        wait_done(W);
        check("idle_as_s", 32'(as_s), 0);
        check("idle_as_b", 32'(as_b), 0);

        // 2: boundary values
        do_start(6'd63, 6'd1);  wait_done(W);
        do_start(6'd3, 6'd8);   wait_done(W);
        do_start(6'd63, 6'd63); wait_done(W);

        // 3: divide by zero, then a normal division clears the flag
        do_start(6'd20, 6'd0);  wait_done(0);
        do_start(6'd10, 6'd3);  wait_done(W);

        // 4: start during ITER is ignored; back-to-back start after done
        do_start(6'd43, 6'd5);
        @(negedge clk);
        dividend = 6'd9;
        divisor  = 6'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(W);
        do_start(6'd44, 6'd6);  wait_done(W);

        // 5: asynchronous reset in the 3rd ITER cycle aborts with no done
        do_start(6'd43, 6'd5);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_quotient", 32'(quotient), 0);
        check("arst_remainder", 32'(remainder), 0);
        check("arst_as_a", 32'(as_a), 0);
        check("arst_as_s", 32'(as_s), 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        expect_quiet(3);
        do_start(6'd50, 6'd7);  wait_done(W);

`ifdef ADDSUB_DIV_ABORT_EN
        // 6: abort in the 2nd ITER cycle keeps previous results
        do_start(6'd43, 6'd5);  wait_done(W);
        do_start(6'd50, 6'd7);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        void'(exp_q.pop_back());
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_quotient", 32'(quotient), 8);
        check("abort_remainder", 32'(remainder), 3);
        check("abort_dbz", 32'(div_by_zero), 0);
        expect_quiet(3);
`endif

        // random divisions, occasionally by zero
        for (int i = 0; i < 8; i++) begin
            rdd = W'($urandom_range(0, 63));
            rdv = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 63));
            do_start(rdd, rdv);
            wait_done((rdv == '0) ? 0 : W);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
